// File: rtl/bus_master_port_p_if.sv
// ---------------------------------------------------------------------------
// bus_master_port_p_if
// Serial system-bus bundle between one bus master port and a slave port.
//   mode          master -> slave  bus direction (1 = write, 0 = read)
//   wr_bus        master -> slave  serial address / write data, LSB first
//   master_valid  master -> slave  wr_bus bit is valid
//   slave_ready   slave  -> master slave accepts the wr_bus bit
//   rd_bus        slave  -> master serial read data, LSB first
//   slave_valid   slave  -> master rd_bus bit is valid
//   master_ready  master -> slave  master accepts the rd_bus bit
// Handshake: a bit moves on a rising edge where the sender's valid and the
// receiver's ready are both high; the sender holds the bit and keeps valid
// high until that edge, and the bit index advances only on that edge.
// ---------------------------------------------------------------------------
interface bus_master_port_p_if;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic slave_ready;
  logic rd_bus;
  logic slave_valid;
  logic master_ready;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  slave_ready, rd_bus, slave_valid
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output slave_ready, rd_bus, slave_valid
  );
endinterface

// File: rtl/bus_master_port_p.sv
// ---------------------------------------------------------------------------
// bus_master_port_p
// Parametrised serial bus master port. Turns a parallel read/write burst
// request from local logic into a bit-serial transaction: address once
// (ADDR_W bits), then 1..BURST_MAX data beats of DATA_W bits, all LSB first.
// Burst beats share the one address; the slave auto-increments.
//
// Optional feature macro: BMP_TIMEOUT_EN
//   defined     : a stall counter aborts the transfer after TIMEOUT_CYC
//                 consecutive stalled cycles (ERR state, m_err+m_done pulse).
//   not defined : the master waits indefinitely, m_err is tied 0.
//
// Ports
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   m_start        request strobe, only looked at in IDLE
//   m_mode         1 = write, 0 = read
//   m_addr         start address
//   m_burst_len    beats-1, clamped to BURST_MAX-1
//   m_wr_data      write beat data (beat 0 at start, later beats on m_wr_req)
//   m_wr_req       pulse: m_wr_data is captured as the next beat this edge
//   m_rd_data      last completed read beat
//   m_rd_valid     pulse: m_rd_data just updated
//   m_busy         transfer in progress (any state but IDLE)
//   m_done         one-cycle completion pulse (also on timeout abort)
//   m_err          one-cycle timeout pulse
//   dbg_state      current FSM state encoding
//   bus            serial bus, master modport
// ---------------------------------------------------------------------------
module bus_master_port_p #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int BURST_MAX   = 4,
  parameter int TIMEOUT_CYC = 64,
  localparam int BL_W       = $clog2(BURST_MAX)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m_start,
  input  logic              m_mode,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [BL_W-1:0]   m_burst_len,
  input  logic [DATA_W-1:0] m_wr_data,
  output logic              m_wr_req,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_valid,
  output logic              m_busy,
  output logic              m_done,
  output logic              m_err,
  output logic [2:0]        dbg_state,
  bus_master_port_p_if.master bus
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W);

  if (BURST_MAX < 2 || TIMEOUT_CYC < 1 || DATA_W < 3) begin : g_param_check
    $error("bus_master_port_p: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  // Holds the first DATA_W-1 bits of a read beat; the last bit is taken
  // straight from rd_bus when the beat completes.
  logic [DATA_W-2:0]   rd_sh_q, rd_sh_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BL_W-1:0]     beat_q, beat_d;
  logic [BL_W-1:0]     len_q, len_d;
  logic [DATA_W-1:0]   m_rd_data_q, m_rd_data_d;
  logic                m_rd_valid_q, m_rd_valid_d;
  logic                m_wr_req_c;

  logic                drive_wr;
  logic                wr_acc;
  logic                rd_acc;
  logic [BL_W-1:0]     len_clamped;

  assign drive_wr    = (state_q == S_ADDR) || (state_q == S_WDATA);
  assign wr_acc      = drive_wr && bus.slave_ready;
  assign rd_acc      = (state_q == S_RDATA) && bus.slave_valid;
  assign len_clamped = (m_burst_len > BL_W'(BURST_MAX - 1)) ? BL_W'(BURST_MAX - 1)
                                                            : m_burst_len;

`ifdef BMP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            stalled;

  // In ADDR/WDATA master_valid is always high, so a stall is simply
  // !slave_ready; in RDATA master_ready is always high, so it is !slave_valid.
  assign stalled = (drive_wr && !bus.slave_ready) ||
                   ((state_q == S_RDATA) && !bus.slave_valid);
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_sh_d    = addr_sh_q;
    wbuf_d       = wbuf_q;
    rd_sh_d      = rd_sh_q;
    bit_cnt_d    = bit_cnt_q;
    beat_d       = beat_q;
    len_d        = len_q;
    m_rd_data_d  = m_rd_data_q;
    m_rd_valid_d = 1'b0;
    m_wr_req_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m_start) begin
          state_d   = S_ADDR;
          mode_d    = m_mode;
          addr_sh_d = m_addr;
          wbuf_d    = m_wr_data;
          len_d     = len_clamped;
          rd_sh_d   = '0;
          bit_cnt_d = '0;
          beat_d    = '0;
        end
      end

      S_ADDR: begin
        if (wr_acc) begin
          addr_sh_d = {1'b0, addr_sh_q[ADDR_W-1:1]};
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = mode_q ? S_WDATA : S_RDATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      S_WDATA: begin
        if (wr_acc) begin
          wbuf_d = {1'b0, wbuf_q[DATA_W-1:1]};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (beat_q == len_q) begin
              state_d = S_DONE;
            end else begin
              // Next beat loads on the same edge so its first bit follows
              // without a gap cycle.
              beat_d     = beat_q + BL_W'(1);
              wbuf_d     = m_wr_data;
              m_wr_req_c = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      S_RDATA: begin
        if (rd_acc) begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d    = '0;
            m_rd_data_d  = {bus.rd_bus, rd_sh_q};
            m_rd_valid_d = 1'b1;
            if (beat_q == len_q) begin
              state_d = S_DONE;
            end else begin
              beat_d = beat_q + BL_W'(1);
            end
          end else begin
            rd_sh_d   = {bus.rd_bus, rd_sh_q[DATA_W-2:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BMP_TIMEOUT_EN
  always_comb begin
    stall_cnt_d = '0;
    if (stalled) begin
      stall_cnt_d = stall_cnt_q + TO_W'(1);
    end
  end
`endif

  // Timeout overrides the FSM next state; a stalled cycle never accepts a
  // bit, so nothing else in the next-state logic is active at that point.
  state_e state_final;
  always_comb begin
    state_final = state_d;
`ifdef BMP_TIMEOUT_EN
    if (stalled && (stall_cnt_q == TO_W'(TIMEOUT_CYC - 1))) begin
      state_final = S_ERR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      addr_sh_q    <= '0;
      wbuf_q       <= '0;
      rd_sh_q      <= '0;
      bit_cnt_q    <= '0;
      beat_q       <= '0;
      len_q        <= '0;
      m_rd_data_q  <= '0;
      m_rd_valid_q <= 1'b0;
    end else begin
      state_q      <= state_final;
      mode_q       <= mode_d;
      addr_sh_q    <= addr_sh_d;
      wbuf_q       <= wbuf_d;
      rd_sh_q      <= rd_sh_d;
      bit_cnt_q    <= bit_cnt_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      m_rd_data_q  <= m_rd_data_d;
      m_rd_valid_q <= m_rd_valid_d;
    end
  end

`ifdef BMP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign m_err = (state_q == S_ERR);
`else
  assign m_err = 1'b0;
`endif

  // All outputs decode from flops that clear asynchronously, so an
  // asserted rstn forces them low without waiting for a clock edge.
  assign bus.master_valid = drive_wr;
  assign bus.master_ready = (state_q == S_RDATA);
  assign bus.wr_bus       = (state_q == S_ADDR)  ? addr_sh_q[0] :
                            (state_q == S_WDATA) ? wbuf_q[0]    : 1'b0;
  assign bus.mode         = mode_q && (drive_wr || (state_q == S_RDATA));

  assign m_wr_req   = m_wr_req_c;
  assign m_rd_data  = m_rd_data_q;
  assign m_rd_valid = m_rd_valid_q;
  assign m_busy     = (state_q != S_IDLE);
  assign m_done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bus_master_port_p.sv
// ---------------------------------------------------------------------------
// tb_bus_master_port_p
// Directed bench for bus_master_port_p with default parameters
// (ADDR_W=16, DATA_W=8, BURST_MAX=4). The bench plays the slave: it drives
// slave_ready / slave_valid / rd_bus on the falling edge and samples the
// master 1 ns later. Expected serial bits are queued in exp_q and popped on
// every accepted bit. Latency k = index of the falling edge (counted from
// the edge that captured m_start) on which m_done is first seen high, i.e.
// the rising edge at which a synchronous consumer would sample it.
// ---------------------------------------------------------------------------
module tb_bus_master_port_p;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m_start = 1'b0;
  logic        m_mode = 1'b0;
  logic [15:0] m_addr = '0;
  logic [1:0]  m_burst_len = '0;
  logic [7:0]  m_wr_data = '0;
  logic        m_wr_req;
  logic [7:0]  m_rd_data;
  logic        m_rd_valid;
  logic        m_busy;
  logic        m_done;
  logic        m_err;
  logic [2:0]  dbg_state;

  bus_master_port_p_if bus_if ();

  bus_master_port_p dut (
    .clk         (clk),
    .rstn        (rstn),
    .m_start     (m_start),
    .m_mode      (m_mode),
    .m_addr      (m_addr),
    .m_burst_len (m_burst_len),
    .m_wr_data   (m_wr_data),
    .m_wr_req    (m_wr_req),
    .m_rd_data   (m_rd_data),
    .m_rd_valid  (m_rd_valid),
    .m_busy      (m_busy),
    .m_done      (m_done),
    .m_err       (m_err),
    .dbg_state   (dbg_state),
    .bus         (bus_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},   32'(m_busy), 0);
    chk({tag, "_done"},   32'(m_done), 0);
    chk({tag, "_state"},  32'(dbg_state), 0);
    chk({tag, "_mode"},   32'(bus_if.mode), 0);
    chk({tag, "_wr_bus"}, 32'(bus_if.wr_bus), 0);
    chk({tag, "_mvalid"}, 32'(bus_if.master_valid), 0);
  endtask

  // One full transaction as seen from both the requester and the slave.
  // stall_n=0 disables the stall window, busy_start_at=0 disables the
  // extra m_start pulse issued while the port is busy.
  task automatic xfer(input string tag, input logic wr, input logic [15:0] addr,
                      input logic [1:0] len, input logic [31:0] wdat,
                      input logic [31:0] rdat, input int stall_at, input int stall_n,
                      input int busy_start_at, input int exp_lat, input logic exp_err);
    int   k, lat, rd_idx, beat_w, n_wrreq, n_rdv;
    bit   upd, stalled, prev_stall, mode_bad, frozen_bad, busy_bad;
    logic prev_wr, err_seen;
    k = 0; lat = -1; rd_idx = 0; beat_w = 1; n_wrreq = 0; n_rdv = 0;
    upd = 0; prev_stall = 0; mode_bad = 0; frozen_bad = 0; busy_bad = 0;
    prev_wr = 1'b0; err_seen = 1'b0;

    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(addr[i]);
    if (wr) begin
      for (int b = 0; b <= int'(len); b++)
        for (int i = 0; i < 8; i++) exp_q.push_back(wdat[8*b+i]);
    end

    @(negedge clk);
    m_start = 1'b1; m_mode = wr; m_addr = addr; m_burst_len = len;
    m_wr_data = wdat[7:0];
    bus_if.slave_ready = 1'b1; bus_if.slave_valid = 1'b1; bus_if.rd_bus = rdat[0];

    while (k < 1000 && lat < 0) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        m_start = 1'b0;
        m_wr_data = wdat[15:8];
        beat_w = 2;
      end
      if (k == busy_start_at) begin
        m_start = 1'b1; m_mode = ~wr; m_addr = ~addr;
      end else if (k == busy_start_at + 1) begin
        m_start = 1'b0;
      end
      if (upd) begin
        if (beat_w < 4) m_wr_data = wdat[8*beat_w +: 8];
        beat_w++;
        upd = 0;
      end
      stalled = (stall_n > 0) && (k >= stall_at) && (k < stall_at + stall_n);
      bus_if.slave_ready = !stalled;
      bus_if.slave_valid = !stalled;
      bus_if.rd_bus      = (rd_idx < 32) ? rdat[rd_idx] : 1'b0;
      #1;
      if (!m_busy) busy_bad = 1;
      if ((bus_if.master_valid || bus_if.master_ready) && (bus_if.mode !== wr)) mode_bad = 1;
      if (prev_stall && bus_if.master_valid && (bus_if.wr_bus !== prev_wr)) frozen_bad = 1;
      prev_stall = stalled && bus_if.master_valid;
      prev_wr    = bus_if.wr_bus;
      if (bus_if.master_valid && bus_if.slave_ready) begin
        if (exp_q.size() > 0) chk({tag, "_wr_bit"}, 32'(bus_if.wr_bus), 32'(exp_q.pop_front()));
        else                  chk({tag, "_wr_bit_extra"}, 32'(bus_if.master_valid), 0);
      end
      if (m_wr_req) begin
        n_wrreq++;
        upd = 1;
      end
      if (bus_if.master_ready && bus_if.slave_valid) rd_idx++;
      if (m_rd_valid) begin
        if (n_rdv < 4) chk({tag, "_rd_beat"}, 32'(m_rd_data), 32'(rdat[8*n_rdv +: 8]));
        n_rdv++;
      end
      if (m_done) begin
        lat = k;
        err_seen = m_err;
      end
    end

    chk({tag, "_latency"},  lat, exp_lat);
    chk({tag, "_m_err"},    32'(err_seen), 32'(exp_err));
    chk({tag, "_wr_req_n"}, n_wrreq, (wr && !exp_err) ? int'(len) : 0);
    chk({tag, "_rd_vld_n"}, n_rdv, (!wr && !exp_err) ? int'(len) + 1 : 0);
    chk({tag, "_mode_held"}, 32'(mode_bad), 0);
    chk({tag, "_busy_held"}, 32'(busy_bad), 0);
    if (stall_n > 0 && !exp_err) chk({tag, "_frozen"}, 32'(frozen_bad), 0);
    if (!exp_err) chk({tag, "_bits_left"}, exp_q.size(), 0);

    @(negedge clk);
    bus_if.slave_ready = 1'b1; bus_if.slave_valid = 1'b1;
    #1;
    chk_idle({tag, "_after"});
    chk({tag, "_err_after"}, 32'(m_err), 0);
  endtask

  initial begin
    bus_if.slave_ready = 1'b0;
    bus_if.slave_valid = 1'b0;
    bus_if.rd_bus      = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_mready", 32'(bus_if.master_ready), 0);
    chk("reset_rd_vld", 32'(m_rd_valid), 0);
    chk("reset_rd_data", 32'(m_rd_data), 0);
    chk("reset_wr_req", 32'(m_wr_req), 0);
    chk("reset_err", 32'(m_err), 0);
    @(negedge clk);
    rstn = 1'b1;

    // single write F234 / 5A: 16 + 8 + 1
    xfer("wr1", 1'b1, 16'hF234, 2'd0, 32'h0000005A, 32'h0, 0, 0, 0, 25, 1'b0);
    // single read F234, slave returns A5
    xfer("rd1", 1'b0, 16'hF234, 2'd0, 32'h0, 32'h000000A5, 0, 0, 0, 25, 1'b0);
    // burst write 11,22,33: 16 + 24 + 1
    xfer("wrb", 1'b1, 16'h1C07, 2'd2, 32'h00332211, 32'h0, 0, 0, 0, 41, 1'b0);
    // slave_ready low for 5 cycles mid-address
    xfer("wrst", 1'b1, 16'hF234, 2'd0, 32'h0000005A, 32'h0, 5, 5, 0, 30, 1'b0);
    // 4-beat read burst: 16 + 32 + 1
    xfer("rdb", 1'b0, 16'h8001, 2'd3, 32'h0, 32'hFE0196C3, 0, 0, 0, 49, 1'b0);
    // read with slave_valid low for 3 cycles mid-beat
    xfer("rdst", 1'b0, 16'h00FF, 2'd0, 32'h0, 32'h0000003C, 20, 3, 0, 28, 1'b0);
    // m_start with different request while busy must be ignored
    xfer("busy", 1'b1, 16'hA5C3, 2'd1, 32'h00007E81, 32'h0, 0, 0, 6, 33, 1'b0);

`ifdef BMP_TIMEOUT_EN
    // slave_ready stuck low from the first address bit: abort after 64 stalls
    xfer("tmo", 1'b1, 16'hF234, 2'd0, 32'h0000005A, 32'h0, 1, 1000, 0, 65, 1'b1);
`endif

    // asynchronous reset in the middle of WDATA
    @(negedge clk);
    m_start = 1'b1; m_mode = 1'b1; m_addr = 16'h1234; m_burst_len = 2'd0; m_wr_data = 8'hC3;
    @(negedge clk);
    m_start = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    chk("rst_mid_state_before", 32'(dbg_state), 2);
    #1;
    rstn = 1'b0;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_err", 32'(m_err), 0);
    @(negedge clk);
    rstn = 1'b1;
    xfer("wr_post_rst", 1'b1, 16'hF234, 2'd0, 32'h0000005A, 32'h0, 0, 0, 0, 25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
